ps2_transmitter: RTL and testbench

- Host-to-device PS/2 transmitter; the counterpart of the existing PS/2 receiver.
- Sends command bytes to the keyboard: LED control (0xED + mask), reset (0xFF), typematic (0xF3).
- Sits beside the receiver in the keyboard path. Drives PS2CLK/PS2DAT as open-collector through two active-high pull-low enables.
- Asserts busy so the receiver and keymatrix ignore the clocks it generates.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_line_filter.sv | 48 ++++
 rtl/ps2_transmitter.sv | 150 +++++++++++++++
 tb/tb_ps2_transmitter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and timing defaults for the PS/2 host-side keyboard path.
`timescale 1ns/1ps
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE} ps2_tx_state_e;

  localparam logic [3:0] IDX_PARITY = 4'd8;
  localparam logic [3:0] IDX_STOP   = 4'd9;

  // Defaults assume the 28.375 MHz CLK28 domain.
  localparam int DEF_INHIBIT_CYCLES = 2838;
  localparam int DEF_TIMEOUT_CYCLES = 425625;
  localparam int DEF_FILTER_LEN     = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronizer, run-length glitch filter and
// a one-cycle pulse on each accepted 1->0 transition.
`timescale 1ns/1ps
module ps2_line_filter import ps2_pkg::*; #(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    meta_q, meta_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d  = {meta_q[0], pin};
    level_d = level_q;
    cnt_d   = '0;
    // A new level is adopted only after FILTER_LEN consecutive disagreeing samples.
    if (meta_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) level_d = meta_q[1];
      else                              cnt_d   = cnt_q + 1'b1;
    end
    fall_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;
endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, shift
// D0..D7/parity/stop on device clock falls, then check the device acknowledge.
`timescale 1ns/1ps
module ps2_transmitter import ps2_pkg::*; #(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  ps2_tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]    dsync_q, dsync_d;
  logic          clk_level, clk_fall, dat;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset_n(reset_n), .pin(ps2_clk_in), .level(clk_level), .fall(clk_fall)
  );

  assign dat = dsync_q[1];

  always_comb begin
    dsync_d   = {dsync_q[0], ps2_data_in};
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // A request coinciding with a completion pulse is dropped on purpose.
        if (tx_start && !done_q && !err_q) begin
          data_d   = tx_data;
          par_d    = odd_parity(tx_data);
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = RELEASE;
        end else cnt_d = cnt_q + 1'b1;
      end
      RELEASE: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: if (clk_fall) begin
        cnt_d = '0;
        idx_d = idx_q + 4'd1;
        if (idx_q == IDX_STOP) begin
          data_oe_d = 1'b0;
          idx_d     = idx_q;
          state_d   = ACK;
        end else if (idx_q == IDX_PARITY) data_oe_d = ~par_q;
        else                              data_oe_d = ~data_q[idx_q[2:0]];
      end
      ACK: if (clk_fall) begin
        cnt_d = '0;
        if (dat) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else state_d = WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_level && dat) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog on the device clock; every accepted fall restarts it.
    if ((state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) && !clk_fall && !done_d) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        err_d     = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dsync_q   <= 2'b11;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dsync_q   <= dsync_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;
endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with an open-collector keyboard model.
`timescale 1ns/1ps
module tb_ps2_transmitter;
  localparam int INH = 40;
  localparam int TMO = 600;
  localparam int FLT = 8;
  localparam int H   = 20;

  logic       clk = 1'b0, reset_n = 1'b0, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  int checks = 0, errors = 0;
  int n_done = 0, n_err = 0, n_both = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_error) n_err++;
    if (tx_done && tx_error) n_both++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, output logic oe_before, output logic oe_after, output logic busy_after);
    @(posedge clk); #1;
    tx_data = d; tx_start = 1'b1;
    @(negedge clk); oe_before = ps2_clk_oe;
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk); oe_after = ps2_clk_oe; busy_after = busy;
  endtask

  // Keyboard model: waits for release, clocks 11 periods, samples data late in each low phase.
  task automatic dev_frame(input bit ack, input int glitch_k, input int abort_k,
                           output logic [9:0] got, output int inh_len, output bit start_ok, output bit ok);
    int t;
    got = '0; inh_len = 0; start_ok = 1'b0; ok = 1'b0; t = 0;
    do begin
      @(negedge clk); t++;
      if (ps2_clk_oe) inh_len++;
    end while (ps2_clk_oe && t < 5000);
    if (ps2_clk_oe) return;
    start_ok = (ps2_data_in == 1'b0);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      if (k == abort_k) begin
        repeat (H / 2) @(negedge clk);
        ok = 1'b1;
        return;
      end
      repeat (H - 1) @(negedge clk);
      if (k <= 10) got[k-1] = ps2_data_in;
      @(negedge clk);
      dev_clk_low = 1'b0;
      if (k == glitch_k) begin
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (H - 10) @(negedge clk);
      end else repeat (H) @(negedge clk);
    end
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_result(input int bd, input int be);
    int t;
    t = 0;
    while (n_done == bd && n_err == be && t < 300) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input int glitch_k, input string tag);
    logic ob, oa, ba;
    logic [9:0] got, exp;
    int inh, bd, be;
    bit st, ok;
    bd = n_done; be = n_err;
    exp = {1'b1, par, d};
    send(d, ob, oa, ba);
    checks++; if (ob !== 1'b0) begin errors++; $display("FAIL %s clk_oe_before_accept: got %b expected 0", tag, ob); end
    checks++; if (oa !== 1'b1 || ba !== 1'b1) begin errors++; $display("FAIL %s clk_oe_busy_latency: got %b%b expected 11", tag, oa, ba); end
    dev_frame(1'b1, glitch_k, 0, got, inh, st, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s release_seen: got 0 expected 1", tag); end
    checks++; if (!st) begin errors++; $display("FAIL %s start_bit: got 1 expected 0", tag); end
    checks++; if (inh + 1 < INH || inh + 1 > INH + 2) begin errors++; $display("FAIL %s inhibit_len: got %0d expected %0d..%0d", tag, inh + 1, INH, INH + 2); end
    checks++; if (got !== exp) begin errors++; $display("FAIL %s frame_bits: got %b expected %b", tag, got, exp); end
    wait_result(bd, be);
    checks++; if (n_done - bd !== 1 || n_err - be !== 0) begin errors++; $display("FAIL %s pulses: got done=%0d err=%0d expected 1/0", tag, n_done - bd, n_err - be); end
    checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL %s idle_after: got busy/clk/data=%b%b%b expected 000", tag, busy, ps2_clk_oe, ps2_data_oe); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error}); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error} !== 5'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 00000", {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error}); end
  endtask

  task automatic test_led_frame();
    run_frame(8'hED, 1'b1, 0, "led_ed");
  endtask

  task automatic test_parity();
    run_frame(8'h01, 1'b0, 0, "parity_01");
    run_frame(8'h00, 1'b1, 0, "parity_00");
  endtask

  task automatic test_start_on_done();
    logic ob, oa, ba;
    logic [9:0] got;
    int inh, t;
    bit st, ok;
    send(8'hA5, ob, oa, ba);
    dev_frame(1'b1, 0, 0, got, inh, st, ok);
    t = 0;
    while (!tx_done && t < 300) begin @(negedge clk); t++; end
    checks++; if (t >= 300) begin errors++; $display("FAIL done_wait: got timeout expected tx_done"); end
    tx_data = 8'h5A; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL start_on_done_ignored: got busy/clk_oe=%b%b expected 00", busy, ps2_clk_oe); end
    run_frame(8'h5A, 1'b1, 0, "reissue_5a");
  endtask

  task automatic test_no_ack();
    logic ob, oa, ba;
    logic [9:0] got;
    int inh, bd, be;
    bit st, ok;
    bd = n_done; be = n_err;
    send(8'h12, ob, oa, ba);
    dev_frame(1'b0, 0, 0, got, inh, st, ok);
    wait_result(bd, be);
    checks++; if (n_err - be !== 1 || n_done - bd !== 0) begin errors++; $display("FAIL no_ack_pulses: got done=%0d err=%0d expected 0/1", n_done - bd, n_err - be); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL no_ack_lines: got clk/data/busy=%b%b%b expected 000", ps2_clk_oe, ps2_data_oe, busy); end
  endtask

  task automatic test_timeout();
    logic ob, oa, ba;
    int t, bd;
    bd = n_done;
    send(8'hAA, ob, oa, ba);
    t = 0;
    do begin @(negedge clk); t++; end while (ps2_clk_oe && t < 5000);
    t = 0;
    while (!tx_error && t < TMO + 100) begin @(negedge clk); t++; end
    checks++; if (t !== TMO) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", t, TMO); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_lines: got clk/data/busy=%b%b%b expected 000", ps2_clk_oe, ps2_data_oe, busy); end
    repeat (5) @(negedge clk);
    checks++; if (n_done !== bd) begin errors++; $display("FAIL timeout_no_done: got %0d expected %0d", n_done, bd); end
  endtask

  task automatic test_mid_frame_start();
    logic ob, oa, ba;
    logic [9:0] got;
    int inh, bd, be;
    bit st, ok;
    bd = n_done; be = n_err;
    send(8'hF3, ob, oa, ba);
    fork
      dev_frame(1'b1, 0, 0, got, inh, st, ok);
      begin
        repeat (150) @(posedge clk);
        #1 tx_data = 8'h55; tx_start = 1'b1;
        @(posedge clk); #1 tx_start = 1'b0;
      end
    join
    checks++; if (got !== 10'b11_1111_0011) begin errors++; $display("FAIL mid_start_frame: got %b expected %b", got, 10'b11_1111_0011); end
    wait_result(bd, be);
    repeat (50) @(negedge clk);
    checks++; if (n_done - bd !== 1 || n_err - be !== 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_start_pulses: got done=%0d err=%0d busy=%b expected 1/0/0", n_done - bd, n_err - be, busy); end
  endtask

  task automatic test_reset_mid();
    logic ob, oa, ba;
    logic [9:0] got;
    int inh, bd, be;
    bit st, ok;
    bd = n_done; be = n_err;
    send(8'h3C, ob, oa, ba);
    dev_frame(1'b1, 0, 5, got, inh, st, ok);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_lines: got clk/data/busy=%b%b%b expected 000", ps2_clk_oe, ps2_data_oe, busy); end
    dev_clk_low = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (n_done !== bd || n_err !== be) begin errors++; $display("FAIL reset_no_pulses: got done=%0d err=%0d expected 0/0", n_done - bd, n_err - be); end
    run_frame(8'hFF, 1'b1, 0, "after_reset_ff");
  endtask

  task automatic test_glitch();
    run_frame(8'h96, 1'b1, 4, "glitch_96");
  endtask

  task automatic test_exclusive();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL done_error_overlap: got %0d expected 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_led_frame();
    test_parity();
    test_start_on_done();
    test_no_ack();
    test_timeout();
    test_mid_frame_start();
    test_reset_mid();
    test_glitch();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
